// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: operation codes, FSM states and a shift-op helper.
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLL  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_EQ   = 4'b1000,
        OP_SLT  = 4'b1001,
        OP_SLTU = 4'b1010,
        OP_NE   = 4'b1011,
        OP_LT   = 4'b1100,
        OP_GE   = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT,
        ST_DONE
    } alu_state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational one-bit shifter: left, logical right, or arithmetic right.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  shift_left,
    input  logic                  arith,
    output logic [DATA_WIDTH-1:0] shifted
);

    always_comb begin
        if (shift_left) begin
            shifted = {data[DATA_WIDTH-2:0], 1'b0};
        end else begin
            shifted = {arith & data[DATA_WIDTH-1], data[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iterative_alu.sv
// Valid/ready ALU: one-cycle logic/arith/compare, shifts iterate one bit per cycle.
// Define ITERATIVE_ALU_BARREL_SHIFT_EN to compute shifts in a single cycle instead.
module iterative_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  illegal_op
);

    alu_state_e state;
    alu_state_e state_next;

    alu_op_e               op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   shift_op;

    logic [DATA_WIDTH-1:0] shift_value;
    logic [DATA_WIDTH-1:0] exec_value;
    logic                  exec_illegal;

    assign a_s      = a_q;
    assign b_s      = b_q;
    assign shamt    = b_q[SHAMT_WIDTH-1:0];
    assign shift_op = is_shift_op(op_q);

    function automatic logic [DATA_WIDTH-1:0] flag(input logic cond);
        logic [DATA_WIDTH-1:0] v;
        v    = '0;
        v[0] = cond;
        return v;
    endfunction

`ifdef ITERATIVE_ALU_BARREL_SHIFT_EN
    // Cascade of single-bit steps; stage i is bypassed once i reaches the shift amount.
    logic [DATA_WIDTH-1:0] chain [DATA_WIDTH];

    assign chain[0] = a_q;

    for (genvar i = 0; i < DATA_WIDTH - 1; i++) begin : g_barrel
        logic [DATA_WIDTH-1:0] stepped;

        alu_shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
            .data       (chain[i]),
            .shift_left (op_q == OP_SLL),
            .arith      (op_q == OP_SRA),
            .shifted    (stepped)
        );

        assign chain[i+1] = (i < int'(shamt)) ? stepped : chain[i];
    end

    assign shift_value = chain[DATA_WIDTH-1];
`else
    logic [DATA_WIDTH-1:0]  work;
    logic [DATA_WIDTH-1:0]  work_step;
    logic [SHAMT_WIDTH-1:0] count;

    alu_shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .data       (work),
        .shift_left (op_q == OP_SLL),
        .arith      (op_q == OP_SRA),
        .shifted    (work_step)
    );

    // Only a zero-amount shift completes from EXEC; it returns operand_a unchanged.
    assign shift_value = a_q;
`endif

    always_comb begin
        exec_value   = '0;
        exec_illegal = 1'b0;
        case (op_q)
            OP_AND:  exec_value = a_q & b_q;
            OP_SUB:  exec_value = a_q - b_q;
            OP_ADD:  exec_value = a_q + b_q;
            OP_OR:   exec_value = a_q | b_q;
            OP_XOR:  exec_value = a_q ^ b_q;
            OP_SLL, OP_SRL, OP_SRA: exec_value = shift_value;
            OP_EQ:   exec_value = flag(a_q == b_q);
            OP_SLT:  exec_value = flag(a_s < b_s);
            OP_SLTU: exec_value = flag(a_q < b_q);
            OP_NE:   exec_value = flag(a_q != b_q);
            OP_LT:   exec_value = flag(a_s < b_s);
            OP_GE:   exec_value = flag(a_s >= b_s);
            default: exec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
`ifdef ITERATIVE_ALU_BARREL_SHIFT_EN
                state_next = ST_DONE;
`else
                state_next = (shift_op && (shamt != '0)) ? ST_SHIFT : ST_DONE;
`endif
            end
            ST_SHIFT: begin
`ifdef ITERATIVE_ALU_BARREL_SHIFT_EN
                state_next = ST_IDLE;
`else
                if (count == SHAMT_WIDTH'(1)) begin
                    state_next = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture: inputs are frozen here so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_valid) begin
            op_q <= alu_op_e'(operation);
            a_q  <= operand_a;
            b_q  <= operand_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result     <= '0;
            illegal_op <= 1'b0;
`ifndef ITERATIVE_ALU_BARREL_SHIFT_EN
            count      <= '0;
`endif
        end else begin
            if (state == ST_EXEC && state_next == ST_DONE) begin
                result     <= exec_value;
                illegal_op <= exec_illegal;
            end
`ifndef ITERATIVE_ALU_BARREL_SHIFT_EN
            if (state == ST_EXEC) begin
                count <= shamt;
            end else if (state == ST_SHIFT) begin
                count <= count - 1'b1;
            end
            // Result is only written on the final step, so no partial shift is ever visible.
            if (state == ST_SHIFT && count == SHAMT_WIDTH'(1)) begin
                result     <= work_step;
                illegal_op <= 1'b0;
            end
`endif
        end
    end

`ifndef ITERATIVE_ALU_BARREL_SHIFT_EN
    always_ff @(posedge clk) begin
        if (state == ST_EXEC) begin
            work <= a_q;
        end else if (state == ST_SHIFT) begin
            work <= work_step;
        end
    end
`endif

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu: directed cases, backpressure, mid-shift reset, random ops.
module tb_iterative_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   operation = 4'd0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         illegal_op;

    always #5 clk = ~clk;

    iterative_alu #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .illegal_op (illegal_op)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         ill;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;
    bit   rand_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%h, required 0x%h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: results straight from the operation definitions.
    function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        int sh;
        sa = a;
        sb = b;
        sh = int'(b[4:0]);
        case (op)
            4'd0:  return {1'b0, a & b};
            4'd1:  return {1'b0, a - b};
            4'd2:  return {1'b0, a + b};
            4'd3:  return {1'b0, a | b};
            4'd4:  return {1'b0, a ^ b};
            4'd5:  return {1'b0, a << sh};
            4'd6:  return {1'b0, a >> sh};
            4'd7:  return {1'b0, W'(sa >>> sh)};
            4'd8:  return {1'b0, W'(a == b)};
            4'd9:  return {1'b0, W'(sa < sb)};
            4'd10: return {1'b0, W'(a < b)};
            4'd11: return {1'b0, W'(a != b)};
            4'd12: return {1'b0, W'(sa < sb)};
            4'd13: return {1'b0, W'(sa >= sb)};
            default: return {1'b1, {W{1'b0}}};
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] b);
`ifdef ITERATIVE_ALU_BARREL_SHIFT_EN
        return 1;
`else
        if (op >= 4'd5 && op <= 4'd7 && b[4:0] != 5'd0) return 1 + int'(b[4:0]);
        return 1;
`endif
    endfunction

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input bit known, input logic [W-1:0] kres,
                        input logic kill);
        int   waited;
        exp_t e;
        logic [W:0] m;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            fail_now("issue_timeout");
            return;
        end
        operation = op;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operation = 4'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
        if (push) begin
            m = model(op, a, b);
            e.res = known ? kres : m[W-1:0];
            e.ill = known ? kill : m[W];
            e.acc = cyc;
            e.lat = exp_lat(op, b);
            sbq.push_back(e);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        send(op, a, b, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic issue_known(input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] res, input logic ill);
        send(op, a, b, 1'b1, 1'b1, res, ill);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < budget) begin
            @(posedge clk);
            #1;
            out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        if (sbq.size() > 0) begin
            fail_now("drain_timeout");
            sbq.delete();
        end
        out_ready = 1'b1;
    endtask

    // Monitor: latency on out_valid rise, result/illegal_op on each output handshake.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (sbq.size() > 0) check("in_ready_busy", W'(in_ready), W'(0));
            if (out_valid && !prev_valid) begin
                if (sbq.size() == 0) fail_now("spurious_out_valid");
                else check("latency", W'(cyc - sbq[0].acc), W'(sbq[0].lat));
            end
            if (out_valid && out_ready && sbq.size() > 0) begin
                check("result", result, sbq[0].res);
                check("illegal_op", W'(illegal_op), W'(sbq[0].ill));
                void'(sbq.pop_front());
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_result", result, '0);
        check("reset_illegal", W'(illegal_op), W'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", W'(in_ready), W'(1));

        issue_known(4'd2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
        drain(100);
        issue_known(4'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0);
        drain(100);
        issue_known(4'd7, 32'h8000_0000, 32'h3F, 32'hFFFF_FFFF, 1'b0);
        drain(100);
        issue_known(4'd9, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
        issue_known(4'd10, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
        issue_known(4'd13, 32'd5, 32'd5, 32'h1, 1'b0);
        issue_known(4'd11, 32'd5, 32'd5, 32'h0, 1'b0);
        issue_known(4'd14, 32'd3, 32'd4, 32'h0, 1'b1);
        issue_known(4'd0, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0);
        issue_known(4'd15, 32'd7, 32'd9, 32'h0, 1'b1);
        issue_known(4'd5, 32'h1, 32'hFFFF_FFE3, 32'h8, 1'b0);
        issue_known(4'd6, 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0);
        issue_known(4'd12, 32'h8000_0000, 32'h1, 32'h1, 1'b0);
        issue_known(4'd8, 32'h1234, 32'h1234, 32'h1, 1'b0);
        drain(200);

        // Backpressure: result held, no acceptance while DONE.
        out_ready = 1'b0;
        issue_known(4'd4, 32'hFF, 32'hA5, 32'h5A, 1'b0);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) fail_now("bp_wait_valid");
        operation = 4'd2;
        operand_a = 32'h1;
        operand_b = 32'h2;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_result_stable", result, 32'h5A);
            check("bp_in_ready_low", W'(in_ready), W'(0));
            check("bp_out_valid_held", W'(out_valid), W'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_idle", W'(in_ready), W'(1));
        check("bp_release_out_valid", W'(out_valid), W'(0));
        drain(20);

        // Reset in the middle of a 20-bit left shift.
        send(4'd5, 32'h0000_ABCD, 32'd20, 1'b0, 1'b0, '0, 1'b0);
        repeat (14) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_out_valid", W'(out_valid), W'(0));
        check("mid_reset_result", result, '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_reset_in_ready", W'(in_ready), W'(1));
        repeat (40) @(posedge clk);
        #1;
        check("mid_reset_no_output", W'(out_valid), W'(0));
        issue_known(4'd5, 32'h1, 32'h4, 32'h10, 1'b0);
        drain(100);

        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
            issue(rop, ra, rb);
            drain(300);
        end
        rand_bp = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
